// File: rtl/adc_spi_responder_pkg.sv
// Shared definitions for the ADC SPI responder: frame length, pattern encodings, FSM states.
package adc_spi_responder_pkg;

    localparam int unsigned FRAME_BITS = 16;

    localparam logic [1:0] PAT_CONST = 2'd0;
    localparam logic [1:0] PAT_RAMP  = 2'd1;
    localparam logic [1:0] PAT_ALT   = 2'd2;
    localparam logic [1:0] PAT_LFSR  = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with a selectable reset value.
module sync_2ff #(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            q      <= RESET_VAL;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/adc_spi_responder.sv
// Emulated 12-bit serial ADC: answers the FPGA's ADC reader with a generated sample per frame,
// changing sdata on sclk falling edges so the reader can sample on rising edges.
module adc_spi_responder
    import adc_spi_responder_pkg::*;
#(
    parameter int unsigned          DATA_BITS  = 12,
    parameter int unsigned          LEAD_ZEROS = FRAME_BITS - DATA_BITS,
    parameter int unsigned          RAMP_STEP  = 1,
    parameter logic [DATA_BITS-1:0] LFSR_SEED  = 12'hACE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cs_n,
    input  logic                 sclk,
    input  logic [1:0]           pattern_sel,
    input  logic [DATA_BITS-1:0] const_value,
    output logic                 sdata,
    output logic                 busy,
    output logic                 frame_abort,
    output logic [15:0]          conv_count
);

    localparam int unsigned FRAME_LEN = LEAD_ZEROS + DATA_BITS;
    localparam int unsigned CNT_W     = $clog2(FRAME_LEN);

    logic cs_sync, sclk_sync;
    logic cs_prev_q, sclk_prev_q;
    logic cs_fall, cs_rise, sclk_fall;

    state_e                 state_q;
    logic [FRAME_LEN-1:0]   shreg_q;
    logic [CNT_W-1:0]       bit_cnt_q;
    logic                   frame_done;

    logic [DATA_BITS-1:0]   ramp_q;
    logic                   alt_q;
    logic [DATA_BITS-1:0]   lfsr_q;
    logic                   lfsr_fb;
    logic [DATA_BITS-1:0]   sample;
    logic [FRAME_LEN-1:0]   frame_word;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync_cs (
        .clk   (clk),
        .reset (reset),
        .d     (cs_n),
        .q     (cs_sync)
    );

    sync_2ff #(
        .RESET_VAL (1'b0)
    ) u_sync_sclk (
        .clk   (clk),
        .reset (reset),
        .d     (sclk),
        .q     (sclk_sync)
    );

    assign cs_fall   = cs_prev_q & ~cs_sync;
    assign cs_rise   = ~cs_prev_q & cs_sync;
    assign sclk_fall = sclk_prev_q & ~sclk_sync;

    assign frame_done = (state_q == StShift) && sclk_fall && (bit_cnt_q == '0);

    // Shift register is cleared outside SHIFT, so its MSB doubles as the registered sdata.
    assign sdata = shreg_q[FRAME_LEN-1];

    always_comb begin
        sample = const_value;
        unique case (pattern_sel)
            PAT_CONST: sample = const_value;
            PAT_RAMP:  sample = ramp_q;
            PAT_ALT:   sample = {DATA_BITS{alt_q}};
            PAT_LFSR:  sample = lfsr_q;
            default:   sample = const_value;
        endcase
    end

    assign frame_word = {{LEAD_ZEROS{1'b0}}, sample};
    assign lfsr_fb    = lfsr_q[DATA_BITS-1] ^ lfsr_q[5] ^ lfsr_q[3] ^ lfsr_q[0];

    // All generators step together on each completed frame, whichever one is selected.
    always_ff @(posedge clk) begin
        if (reset) begin
            ramp_q <= '0;
            alt_q  <= 1'b0;
            lfsr_q <= LFSR_SEED;
        end else if (frame_done) begin
            ramp_q <= ramp_q + DATA_BITS'(RAMP_STEP);
            alt_q  <= ~alt_q;
            lfsr_q <= {lfsr_q[DATA_BITS-2:0], lfsr_fb};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            busy        <= 1'b0;
            frame_abort <= 1'b0;
            conv_count  <= '0;
            cs_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b0;
        end else begin
            cs_prev_q   <= cs_sync;
            sclk_prev_q <= sclk_sync;
            frame_abort <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cs_fall) begin
                        shreg_q   <= frame_word;
                        bit_cnt_q <= CNT_W'(FRAME_LEN - 1);
                        busy      <= 1'b1;
                        state_q   <= StShift;
                    end
                end
                StShift: begin
                    // A final edge coinciding with cs_rise still completes the frame.
                    if (frame_done) begin
                        shreg_q    <= '0;
                        conv_count <= conv_count + 16'd1;
                        busy       <= 1'b0;
                        state_q    <= cs_rise ? StIdle : StDone;
                    end else if (cs_rise) begin
                        shreg_q     <= '0;
                        frame_abort <= 1'b1;
                        busy        <= 1'b0;
                        state_q     <= StIdle;
                    end else if (sclk_fall) begin
                        shreg_q   <= shreg_q << 1;
                        bit_cnt_q <= bit_cnt_q - CNT_W'(1);
                    end
                end
                StDone: begin
                    if (cs_rise) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench: an SPI master captures frames from the responder and compares them to
// hand-computed values; a narrow 8-bit instance exercises the ramp wrap in few frames.
`timescale 1ns / 1ps
module tb_adc_spi_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs_n, sclk;
    logic [1:0]  pattern_sel;
    logic [11:0] const_value;
    logic        sdata, busy, frame_abort;
    logic [15:0] conv_count;

    logic        cs_n2, sclk2;
    logic        sdata2, busy2, frame_abort2;
    logic [15:0] conv_count2;

    int checks   = 0;
    int failures = 0;
    int abort_cnt = 0;
    logic busy_mid;
    logic [15:0] cap;

    adc_spi_responder u_dut (
        .clk         (clk),
        .reset       (reset),
        .cs_n        (cs_n),
        .sclk        (sclk),
        .pattern_sel (pattern_sel),
        .const_value (const_value),
        .sdata       (sdata),
        .busy        (busy),
        .frame_abort (frame_abort),
        .conv_count  (conv_count)
    );

    adc_spi_responder #(
        .DATA_BITS  (8),
        .LEAD_ZEROS (8),
        .RAMP_STEP  (1),
        .LFSR_SEED  (8'hA5)
    ) u_dut_narrow (
        .clk         (clk),
        .reset       (reset),
        .cs_n        (cs_n2),
        .sclk        (sclk2),
        .pattern_sel (2'd1),
        .const_value (8'h00),
        .sdata       (sdata2),
        .busy        (busy2),
        .frame_abort (frame_abort2),
        .conv_count  (conv_count2)
    );

    always #5 clk = ~clk;

    // Width of each abort pulse shows up directly in this count.
    always @(posedge clk) begin
        if (frame_abort) abort_cnt <= abort_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_cs(input bit narrow, input logic v);
        if (narrow) cs_n2 = v;
        else        cs_n  = v;
    endtask

    task automatic set_sclk(input bit narrow, input logic v);
        if (narrow) sclk2 = v;
        else        sclk  = v;
    endtask

    // mode 0: normal end, 1: cs_n rises with the last falling edge, 2: leave cs_n low.
    task automatic spi_xfer(input bit narrow, input int edges, input int half, input int mode,
                            output logic [15:0] data);
        data = '0;
        set_cs(narrow, 1'b0);
        #(half);
        for (int i = 0; i < edges; i++) begin
            set_sclk(narrow, 1'b1);
            data = {data[14:0], (narrow ? sdata2 : sdata)};
            if (i == 0 && !narrow) busy_mid = busy;
            #(half);
            if (i == edges - 1 && mode == 1) set_cs(narrow, 1'b1);
            set_sclk(narrow, 1'b0);
            #(half);
        end
        if (mode == 0) set_cs(narrow, 1'b1);
        if (mode != 2) #(3 * half + 20);
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        #50;
        reset = 1'b0;
        #30;
    endtask

    initial begin
        reset       = 1'b1;
        cs_n        = 1'b1;
        sclk        = 1'b0;
        cs_n2       = 1'b1;
        sclk2       = 1'b0;
        pattern_sel = 2'd0;
        const_value = 12'hABC;
        busy_mid    = 1'b0;
        #100;
        check_eq("rst_sdata", 32'(sdata), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_abort", 32'(frame_abort), 32'h0);
        check_eq("rst_conv", 32'(conv_count), 32'h0);
        reset = 1'b0;
        #30;

        // Constant pattern
        spi_xfer(1'b0, 16, 70, 0, cap);
        check_eq("const_frame", 32'(cap), 32'h0ABC);
        check_eq("const_busy_mid", 32'(busy_mid), 32'h1);
        check_eq("const_conv", 32'(conv_count), 32'd1);
        check_eq("const_no_abort", 32'(abort_cnt), 32'd0);
        check_eq("const_busy_after", 32'(busy), 32'h0);

        // Ramp; third frame ends with cs_n rising on the final edge
        reset_dut();
        pattern_sel = 2'd1;
        spi_xfer(1'b0, 16, 70, 0, cap);
        check_eq("ramp0", 32'(cap), 32'h0000);
        spi_xfer(1'b0, 16, 70, 0, cap);
        check_eq("ramp1", 32'(cap), 32'h0001);
        spi_xfer(1'b0, 16, 70, 1, cap);
        check_eq("ramp2_simul_rise", 32'(cap), 32'h0002);
        check_eq("ramp_conv", 32'(conv_count), 32'd3);
        check_eq("ramp_no_abort", 32'(abort_cnt), 32'd0);

        // Abort after 8 falling edges
        spi_xfer(1'b0, 8, 70, 0, cap);
        check_eq("abort_pulse_cycles", 32'(abort_cnt), 32'd1);
        check_eq("abort_conv", 32'(conv_count), 32'd3);
        check_eq("abort_busy", 32'(busy), 32'h0);
        spi_xfer(1'b0, 16, 70, 0, cap);
        check_eq("abort_repeat", 32'(cap), 32'h0003);
        check_eq("abort_repeat_conv", 32'(conv_count), 32'd4);

        // Alternate: four completed frames since reset leave the toggle at 0
        pattern_sel = 2'd2;
        spi_xfer(1'b0, 16, 70, 0, cap);
        check_eq("alt0", 32'(cap), 32'h0000);
        spi_xfer(1'b0, 16, 70, 0, cap);
        check_eq("alt1", 32'(cap), 32'h0FFF);
        spi_xfer(1'b0, 16, 70, 0, cap);
        check_eq("alt2", 32'(cap), 32'h0000);
        spi_xfer(1'b0, 16, 70, 0, cap);
        check_eq("alt3", 32'(cap), 32'h0FFF);
        check_eq("alt_conv", 32'(conv_count), 32'd8);

        // LFSR from seed: ACE -> 59C -> B39
        reset_dut();
        pattern_sel = 2'd3;
        spi_xfer(1'b0, 16, 70, 0, cap);
        check_eq("lfsr0", 32'(cap), 32'h0ACE);
        spi_xfer(1'b0, 16, 70, 0, cap);
        check_eq("lfsr1", 32'(cap), 32'h059C);
        spi_xfer(1'b0, 16, 70, 0, cap);
        check_eq("lfsr2", 32'(cap), 32'h0B39);

        // Reset in the middle of a constant 0xFFF frame
        pattern_sel = 2'd0;
        const_value = 12'hFFF;
        spi_xfer(1'b0, 5, 70, 2, cap);
        check_eq("midrst_sdata_before", 32'(sdata), 32'h1);
        check_eq("midrst_busy_before", 32'(busy), 32'h1);
        reset = 1'b1;
        cs_n  = 1'b1;
        #50;
        check_eq("midrst_sdata", 32'(sdata), 32'h0);
        check_eq("midrst_busy", 32'(busy), 32'h0);
        check_eq("midrst_conv", 32'(conv_count), 32'h0);
        reset = 1'b0;
        #50;
        pattern_sel = 2'd1;
        spi_xfer(1'b0, 16, 70, 0, cap);
        check_eq("midrst_ramp0", 32'(cap), 32'h0000);
        check_eq("midrst_conv_after", 32'(conv_count), 32'd1);

        // Narrow instance: 255 fast frames, then capture the wrap 0xFF -> 0x00
        for (int f = 0; f < 255; f++) begin
            spi_xfer(1'b1, 16, 10, 0, cap);
        end
        spi_xfer(1'b1, 16, 70, 0, cap);
        check_eq("wrap_max", 32'(cap), 32'h00FF);
        spi_xfer(1'b1, 16, 70, 0, cap);
        check_eq("wrap_zero", 32'(cap), 32'h0000);
        check_eq("wrap_conv", 32'(conv_count2), 32'd257);
        check_eq("wrap_busy", 32'(busy2), 32'h0);
        check_eq("wrap_abort", 32'(frame_abort2), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
